// File: rtl/regfile_dump_reader.sv
`timescale 1ns/1ps
// Register-file dump sequencer: walks read port 1 over registers 0..NUM_REGS-1 and streams
// (index, data) beats on a valid/ready interface. Define REGDUMP_CSUM_EN to append an XOR checksum beat.
module regfile_dump_reader #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_read_register,
   input  logic [DATA_W-1:0] i_read_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_out_index,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic              o_out_csum,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGDUMP_CSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM, S_FIN} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_FIN} state_t;
`endif

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_idx, w_idx_next;
   logic              r_out_valid, w_out_valid_next;
   logic [ADDR_W-1:0] r_out_index, w_out_index_next;
   logic [DATA_W-1:0] r_out_data, w_out_data_next;
   logic              r_out_last, w_out_last_next;
   logic              r_busy, w_busy_next;
   logic              w_is_last;
`ifdef REGDUMP_CSUM_EN
   logic [DATA_W-1:0] r_csum, w_csum_next;
   logic              r_out_csum, w_out_csum_next;
`endif

   assign w_is_last = (r_idx == LAST_IDX);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
`ifdef REGDUMP_CSUM_EN
         r_csum      <= '0;
         r_out_csum  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_idx       <= w_idx_next;
         r_out_valid <= w_out_valid_next;
         r_out_index <= w_out_index_next;
         r_out_data  <= w_out_data_next;
         r_out_last  <= w_out_last_next;
         r_busy      <= w_busy_next;
`ifdef REGDUMP_CSUM_EN
         r_csum      <= w_csum_next;
         r_out_csum  <= w_out_csum_next;
`endif
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_idx_next       = r_idx;
      w_out_valid_next = r_out_valid;
      w_out_index_next = r_out_index;
      w_out_data_next  = r_out_data;
      w_out_last_next  = r_out_last;
      w_busy_next      = r_busy;
`ifdef REGDUMP_CSUM_EN
      w_csum_next      = r_csum;
      w_out_csum_next  = r_out_csum;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_idx_next   = '0;
               w_busy_next  = 1'b1;
`ifdef REGDUMP_CSUM_EN
               w_csum_next  = '0;
`endif
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_out_data_next  = i_read_data;
            w_out_index_next = r_idx;
            w_out_valid_next = 1'b1;
`ifdef REGDUMP_CSUM_EN
            w_out_last_next  = 1'b0;
            w_out_csum_next  = 1'b0;
            w_csum_next      = r_csum ^ i_read_data;
`else
            w_out_last_next  = w_is_last;
`endif
            w_state_next     = S_SEND;
         end
         S_SEND: begin
            if (r_out_valid && i_out_ready) begin
               w_out_valid_next = 1'b0;
               if (w_is_last) begin
`ifdef REGDUMP_CSUM_EN
                  // Checksum beat is loaded on the same edge the last register beat is accepted.
                  w_out_valid_next = 1'b1;
                  w_out_index_next = '0;
                  w_out_data_next  = r_csum;
                  w_out_last_next  = 1'b1;
                  w_out_csum_next  = 1'b1;
                  w_state_next     = S_CSUM;
`else
                  w_state_next     = S_FIN;
`endif
               end else begin
                  w_idx_next   = r_idx + ADDR_W'(1);
                  w_state_next = S_FETCH;
               end
            end
         end
`ifdef REGDUMP_CSUM_EN
         S_CSUM: begin
            if (r_out_valid && i_out_ready) begin
               w_out_valid_next = 1'b0;
               w_state_next     = S_FIN;
            end
         end
`endif
         S_FIN: begin
            w_busy_next  = 1'b0;
            w_idx_next   = '0;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign o_read_register = r_idx;
   assign o_out_valid     = r_out_valid;
   assign o_out_index     = r_out_index;
   assign o_out_data      = r_out_data;
   assign o_out_last      = r_out_last;
   assign o_busy          = r_busy;
   assign o_done          = (r_state == S_FIN);
`ifdef REGDUMP_CSUM_EN
   assign o_out_csum      = r_out_csum;
`else
   assign o_out_csum      = 1'b0;
`endif

endmodule
